// File: rtl/acc_msg_scheduler.sv
// SHA-256 message scheduler: 16-word sliding window, one W[t] per ms_enable.
// Optional ACC_MS_BYTE_SWAP_EN byte-reverses block words on load (digest path never swapped).
module acc_msg_scheduler #(
  parameter int BLOCK_SIZE  = 512,
  parameter int DIGEST_SIZE = 256,
  parameter int WORD_SIZE   = 32,
  parameter int ROUND_COUNT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ms_init,
  input  logic                   ms_enable,
  input  logic                   msg_sel,
  input  logic [BLOCK_SIZE-1:0]  ms_block_in,
  input  logic [DIGEST_SIZE-1:0] ms_digest_in,
  output logic [31:0]            ms_w,
  output logic                   ms_w_valid,
  output logic [5:0]             ms_round,
  output logic                   ms_done,
  output logic                   ms_busy
);

  localparam int unsigned NWORDS  = 16;
  localparam int unsigned NDIGEST = 8;
  localparam logic [5:0]  LAST    = 6'(ROUND_COUNT - 1);

  typedef enum logic {ST_IDLE, ST_LOADED} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [NWORDS];
  logic [31:0] win_d [NWORDS];
  logic [31:0] load_w [NWORDS];
  logic [5:0]  round_q, round_d;
  logic        done_q, done_d;
  logic [31:0] next_w;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Source words for a load: raw block, or digest followed by fixed 256-bit-message padding.
  always_comb begin
    for (int unsigned i = 0; i < NWORDS; i++) begin
      load_w[i] = '0;
      if (!msg_sel) begin
`ifdef ACC_MS_BYTE_SWAP_EN
        load_w[i] = bswap(ms_block_in[BLOCK_SIZE-1-32*i -: 32]);
`else
        load_w[i] = ms_block_in[BLOCK_SIZE-1-32*i -: 32];
`endif
      end else if (i < NDIGEST) begin
        load_w[i] = ms_digest_in[DIGEST_SIZE-1-32*i -: 32];
      end else if (i == 8) begin
        load_w[i] = 32'h8000_0000;
      end else if (i == 15) begin
        load_w[i] = 32'h0000_0100;
      end
    end
  end

  assign next_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NWORDS; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < NWORDS; i++) win_q[i] <= win_d[i];
    end
  end

  // Init has priority over enable, so a mid-block or final-round init aborts without ms_done.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    for (int unsigned i = 0; i < NWORDS; i++) win_d[i] = win_q[i];
    if (ms_init) begin
      state_d = ST_LOADED;
      round_d = '0;
      for (int unsigned i = 0; i < NWORDS; i++) win_d[i] = load_w[i];
    end else if (state_q == ST_LOADED && ms_enable) begin
      if (round_q == LAST) begin
        state_d = ST_IDLE;
        round_d = '0;
        done_d  = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NWORDS - 1; i++) win_d[i] = win_q[i+1];
        win_d[NWORDS-1] = next_w;
        round_d         = round_q + 6'd1;
      end
    end
  end

  always_comb begin
    ms_w       = win_q[0];
    ms_round   = round_q;
    ms_done    = done_q;
    ms_w_valid = (state_q == ST_LOADED);
    ms_busy    = (state_q == ST_LOADED);
  end

endmodule

// File: tb/tb_acc_msg_scheduler.sv
// Directed bench for acc_msg_scheduler: per-cycle compare against a whole-block schedule model.
module tb_acc_msg_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         ms_init, ms_enable, msg_sel;
  logic [511:0] blk;
  logic [255:0] dig;
  logic [31:0]  ms_w;
  logic         ms_w_valid, ms_done, ms_busy;
  logic [5:0]   ms_round;

  acc_msg_scheduler #(.BLOCK_SIZE(512), .DIGEST_SIZE(256), .WORD_SIZE(32), .ROUND_COUNT(64)) dut (
    .clk(clk), .rst(rst), .ms_init(ms_init), .ms_enable(ms_enable), .msg_sel(msg_sel),
    .ms_block_in(blk), .ms_digest_in(dig), .ms_w(ms_w), .ms_w_valid(ms_w_valid),
    .ms_round(ms_round), .ms_done(ms_done), .ms_busy(ms_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;
  logic [31:0] cap [64];
  logic [31:0] ref1 [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Model: whole 64-word schedule computed at load time; position t advances on accepted enables.
  logic [31:0] m_W [64];
  int          m_t;
  bit          m_busy, m_done, m_wzero;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic model_load();
    logic [31:0] wd;
    for (int t = 0; t < 16; t++) begin
      if (msg_sel) begin
        if (t < 8) m_W[t] = dig[255-32*t -: 32];
        else if (t == 8) m_W[t] = 32'h8000_0000;
        else if (t == 15) m_W[t] = 32'h0000_0100;
        else m_W[t] = 32'h0;
      end else begin
        wd = blk[511-32*t -: 32];
`ifdef ACC_MS_BYTE_SWAP_EN
        wd = {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
`endif
        m_W[t] = wd;
      end
    end
    for (int t = 16; t < 64; t++)
      m_W[t] = ss1(m_W[t-2]) + m_W[t-7] + ss0(m_W[t-15]) + m_W[t-16];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_wzero = 1'b1;
    end else begin
      m_done = 1'b0;
      if (ms_init) begin
        model_load();
        m_t = 0; m_busy = 1'b1; m_wzero = 1'b0;
      end else if (ms_enable && m_busy) begin
        if (m_t == 63) begin
          m_done = 1'b1; m_busy = 1'b0; m_t = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(ms_w_valid), 32'(m_busy));
      chk("busy", 32'(ms_busy), 32'(m_busy));
      chk("round", 32'(ms_round), 32'(m_t));
      chk("done", 32'(ms_done), 32'(m_done));
      if (m_busy) chk("w", ms_w, m_W[m_t]);
      if (m_wzero) chk("w_after_reset", ms_w, 32'h0);
      if (ms_w_valid) cap[ms_round] = ms_w;
      if (ms_done) done_cnt++;
    end
  end

  task automatic step(input bit i, input bit e, input bit s);
    ms_init = i; ms_enable = e; msg_sel = s;
    @(posedge clk);
    #2;
    ms_init = 1'b0; ms_enable = 1'b0;
  endtask

  task automatic clear_cap();
    for (int t = 0; t < 64; t++) cap[t] = 32'hDEAD_BEEF;
  endtask

  int d0, cnt, guard;
  bit e;

  initial begin
    rst = 1'b1; ms_init = 1'b0; ms_enable = 1'b0; msg_sel = 1'b0;
    blk = '0; dig = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_w", ms_w, 32'h0);
    chk("reset_round", 32'(ms_round), 32'h0);
    chk("reset_valid", 32'(ms_w_valid), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Enables in IDLE are ignored.
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Test 1: "abc" block, 64 back-to-back enables.
    blk = {32'h6162_6380, 448'h0, 32'h0000_0018};
    clear_cap();
    d0 = done_cnt;
    step(1'b1, 1'b0, 1'b0);
    repeat (64) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("abc_W0", cap[0], 32'h6162_6380);
    chk("abc_W15", cap[15], 32'h0000_0018);
    chk("abc_W16", cap[16], 32'h6162_6380);
    chk("abc_W17", cap[17], 32'h000F_0000);
    chk("abc_W18", cap[18], 32'h7DA8_6405);
    chk("model_W18", m_W[18], 32'h7DA8_6405);
    chk("abc_done_once", 32'(done_cnt - d0), 32'd1);
    for (int t = 0; t < 64; t++) ref1[t] = cap[t];

    // Test 2: padded digest source.
    dig = {8{32'h1111_1111}};
    clear_cap();
    step(1'b1, 1'b0, 1'b1);
    repeat (64) step(1'b0, 1'b1, 1'b0);
    chk("dig_W0", cap[0], 32'h1111_1111);
    chk("dig_W7", cap[7], 32'h1111_1111);
    chk("dig_W8", cap[8], 32'h8000_0000);
    chk("dig_W9", cap[9], 32'h0);
    chk("dig_W15", cap[15], 32'h0000_0100);

    // Test 3: gapped enables must reproduce the test-1 sequence.
    clear_cap();
    step(1'b1, 1'b0, 1'b0);
    cnt = 0; guard = 0;
    while (cnt < 64 && guard < 1000) begin
      e = 1'($urandom_range(0, 1));
      step(1'b0, e, 1'b0);
      if (e) cnt++;
      guard++;
    end
    chk("gap_budget", 32'(cnt), 32'd64);
    for (int t = 0; t < 64; t++) chk("gap_seq", cap[t], ref1[t]);

    // Init together with enable: init wins.
    step(1'b1, 1'b1, 1'b0);
    chk("init_en_round", 32'(ms_round), 32'h0);
    chk("init_en_w", ms_w, 32'h6162_6380);

    // Test 4: abort at round 20 with a new (digest) block.
    repeat (20) step(1'b0, 1'b1, 1'b0);
    chk("pre_abort_round", 32'(ms_round), 32'd20);
    d0 = done_cnt;
    step(1'b1, 1'b0, 1'b1);
    chk("abort_round", 32'(ms_round), 32'h0);
    chk("abort_w", ms_w, 32'h1111_1111);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Test 5: asynchronous reset at round 40.
    step(1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_w", ms_w, 32'h0);
    chk("rst_mid_busy", 32'(ms_busy), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    chk("rst_round_held", 32'(ms_round), 32'h0);
    chk("rst_w_held", ms_w, 32'h0);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef ACC_MS_BYTE_SWAP_EN
    // Test 6: block words byte-reversed on load, digest words untouched.
    blk = {32'h8063_6261, 448'h0, 32'h1800_0000};
    step(1'b1, 1'b0, 1'b0);
    chk("swap_W0", ms_w, 32'h6162_6380);
    dig = {8{32'h0123_4567}};
    step(1'b1, 1'b0, 1'b1);
    chk("swap_dig_W0", ms_w, 32'h0123_4567);
`endif

    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
